enco_prio_rr: RTL and testbench

- Parametrised, registered successor to the fixed 4-to-2 one-hot encoder in the simple comm system.
- Encodes an N-bit request vector into a W-bit index, in one of two modes:
  - fixed priority (LSB wins);
  - round-robin (rotating priority).
- Flags multi-hot input and presents the result on a valid/ready output stage.
- Sits between the channel-request logic and the TX mux select. Replaces silent default-to-zero with explicit valid signalling.

---
 rtl/enco_pkg.sv | 22 ++
 rtl/enco_prio_core.sv | 32 +++
 rtl/enco_prio_rr.sv | 93 +++++++++
 tb/tb_enco_prio_rr.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enco_pkg.sv
// Shared constants, output-buffer state type and multi-hot helper for the
// priority / round-robin encoder.
package enco_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int CNT_W      = 16;
    localparam int MAX_N      = 64;

    localparam logic [MAX_N-1:0] ONE_MAX = {{(MAX_N-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic multi_hot(input logic [MAX_N-1:0] v);
        return (v & (v - ONE_MAX)) != '0;
    endfunction

endpackage

// File: rtl/enco_prio_core.sv
// Combinational index search: first set request at or above ptr_i, wrapping
// through N-1 back to 0. With ptr_i tied to 0 this is plain lowest-bit-wins.
module enco_prio_core #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    int             pos;

    // Lower copy is masked below ptr; the unmasked upper copy supplies the wrap.
    always_comb begin
        dbl    = {req_i, req_i};
        masked = '0;
        pos    = 0;
        for (int i = 0; i < 2*N; i++) begin
            masked[i] = dbl[i] & (i >= int'(ptr_i));
        end
        for (int i = 2*N-1; i >= 0; i--) begin
            if (masked[i]) pos = i;
        end
        idx_o   = (pos >= N) ? W'(pos - N) : W'(pos);
        found_o = |req_i;
    end

endmodule

// File: rtl/enco_prio_rr.sv
// Registered N-to-W encoder with fixed or round-robin priority, multi-hot
// flag, one-entry valid/ready output buffer and saturating accept counter.
module enco_prio_rr
    import enco_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = $clog2(N),
    parameter int MODE = MODE_FIXED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [N-1:0]     req_i,
    input  logic             ready_i,
    output logic [W-1:0]     code_o,
    output logic             valid_o,
    output logic             multi_o,
    output logic [CNT_W-1:0] cnt_o
);

    buf_state_t       state_q, state_d;
    logic [W-1:0]     code_q, code_d;
    logic             multi_q, multi_d;
    logic [W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [W-1:0] core_ptr;
    logic [W-1:0] idx;
    logic         found;
    logic         accept;
    logic         load;

    // Fixed-priority mode always scans from bit 0.
    assign core_ptr = (MODE == MODE_RR) ? ptr_q : '0;

    enco_prio_core #(
        .N (N),
        .W (W)
    ) u_core (
        .req_i   (req_i),
        .ptr_i   (core_ptr),
        .idx_o   (idx),
        .found_o (found)
    );

    assign accept = (state_q == ST_FULL) & ready_i;
    assign load   = en_i & found & ((state_q == ST_EMPTY) | ready_i);

    // Next-state for buffer, pointer and counter; hold everything by default.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        multi_d = multi_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = ST_FULL;
            code_d  = idx;
            multi_d = multi_hot(MAX_N'(req_i));
            if (MODE == MODE_RR) begin
                ptr_d = (idx == W'(N-1)) ? '0 : idx + W'(1);
            end
        end else if (accept) begin
            state_d = ST_EMPTY;
        end
        if (accept && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops any pending result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            code_q  <= '0;
            multi_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            multi_q <= multi_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign code_o  = code_q;
    assign valid_o = (state_q == ST_FULL);
    assign multi_o = multi_q;
    assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_enco_prio_rr.sv
module tb_enco_prio_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: N=4 fixed priority
    logic        a_en, a_ready;
    logic [3:0]  a_req;
    logic [1:0]  a_code;
    logic        a_valid, a_multi;
    logic [15:0] a_cnt;
    // DUT B: N=5 round-robin
    logic        b_en, b_ready;
    logic [4:0]  b_req;
    logic [2:0]  b_code;
    logic        b_valid, b_multi;
    logic [15:0] b_cnt;

    enco_prio_rr #(.N(4), .MODE(0)) dut_fix (
        .clk(clk), .rst_n(rst_n), .en_i(a_en), .req_i(a_req), .ready_i(a_ready),
        .code_o(a_code), .valid_o(a_valid), .multi_o(a_multi), .cnt_o(a_cnt));

    enco_prio_rr #(.N(5), .MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .en_i(b_en), .req_i(b_req), .ready_i(b_ready),
        .code_o(b_code), .valid_o(b_valid), .multi_o(b_multi), .cnt_o(b_cnt));

    typedef struct {
        bit valid;
        int code;
        bit multi;
        int cnt;
        int ptr;
    } mdl_t;

    mdl_t ma, mb;
    int   checks   = 0;
    int   failures = 0;

    function automatic mdl_t mdl_clear();
        mdl_t r;
        r.valid = 0; r.code = 0; r.multi = 0; r.cnt = 0; r.ptr = 0;
        return r;
    endfunction

    // Behavioural reference: scan from ptr modulo n, count set bits, apply
    // the buffer rules for one clock edge.
    function automatic mdl_t mstep(mdl_t m, int n, int mode, bit en,
                                   logic [63:0] req, bit ready);
        mdl_t r = m;
        int   ones = 0;
        int   idx  = -1;
        for (int k = 0; k < n; k++) if (req[k]) ones++;
        if (m.valid && ready && m.cnt < 65535) r.cnt = m.cnt + 1;
        if (en && ones > 0 && (!m.valid || ready)) begin
            for (int k = 0; k < n; k++) begin
                int j = (m.ptr + k) % n;
                if (req[j] && idx < 0) idx = j;
            end
            r.valid = 1;
            r.code  = idx;
            r.multi = (ones > 1);
            if (mode == 1) r.ptr = (idx + 1) % n;
        end else if (m.valid && ready) begin
            r.valid = 0;
        end
        return r;
    endfunction

    task automatic tick();
        mdl_t na, nb;
        na = mstep(ma, 4, 0, a_en, 64'(a_req), a_ready);
        nb = mstep(mb, 5, 1, b_en, 64'(b_req), b_ready);
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_en = 0; a_req = '0; a_ready = 0;
        b_en = 0; b_req = '0; b_ready = 0;
        ma = mdl_clear(); mb = mdl_clear();
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({a_valid, a_code, a_multi, a_cnt} !== 20'h0) begin
            failures++;
            $display("FAIL reset_fix got v=%b c=%0d m=%b n=%0d want all zero", a_valid, a_code, a_multi, a_cnt);
        end
        checks++;
        if ({b_valid, b_code, b_multi, b_cnt} !== 21'h0) begin
            failures++;
            $display("FAIL reset_rr got v=%b c=%0d m=%b n=%0d want all zero", b_valid, b_code, b_multi, b_cnt);
        end
        #3 rst_n = 1'b1;
    endtask

    task automatic test_fixed_onehot();
        logic [3:0] pat [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        a_en = 1; a_ready = 1;
        for (int i = 0; i < 4; i++) begin
            a_req = pat[i];
            tick();
            checks++;
            if ({a_valid, a_code, a_multi} !== {1'b1, 2'(i), 1'b0}) begin
                failures++;
                $display("FAIL onehot_%0d got v=%b c=%0d m=%b want v=1 c=%0d m=0", i, a_valid, a_code, a_multi, i);
            end
        end
        a_en = 0;
        tick();
        checks++;
        if (a_cnt !== 16'd4 || a_valid !== 1'b0) begin
            failures++;
            $display("FAIL onehot_cnt got cnt=%0d v=%b want cnt=4 v=0", a_cnt, a_valid);
        end
    endtask

    task automatic test_fixed_multi();
        a_en = 1; a_ready = 1; a_req = 4'b1010;
        tick();
        checks++;
        if ({a_valid, a_code, a_multi} !== 4'b1_01_1) begin
            failures++;
            $display("FAIL multi_load got v=%b c=%0d m=%b want v=1 c=1 m=1", a_valid, a_code, a_multi);
        end
        a_req = 4'b0000;
        tick();
        checks++;
        if ({a_valid, a_code, a_multi} !== 4'b0_01_1) begin
            failures++;
            $display("FAIL multi_drain got v=%b c=%0d m=%b want v=0 c=1 m=1", a_valid, a_code, a_multi);
        end
    endtask

    task automatic test_backpressure();
        int cnt0;
        a_en = 1; a_ready = 1; a_req = 4'b0100;
        tick();
        cnt0 = ma.cnt;
        a_ready = 0; a_req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({a_valid, a_code} !== 3'b1_10 || a_cnt !== 16'(cnt0)) begin
                failures++;
                $display("FAIL bp_hold_%0d got v=%b c=%0d cnt=%0d want v=1 c=2 cnt=%0d", i, a_valid, a_code, a_cnt, cnt0);
            end
        end
        a_ready = 1;
        tick();
        checks++;
        if ({a_valid, a_code} !== 3'b1_00 || a_cnt !== 16'(cnt0 + 1)) begin
            failures++;
            $display("FAIL bp_b2b got v=%b c=%0d cnt=%0d want v=1 c=0 cnt=%0d", a_valid, a_code, a_cnt, cnt0 + 1);
        end
        a_en = 0;
        tick();
    endtask

    task automatic test_rr_wrap();
        int exp_codes [6] = '{0, 1, 2, 3, 4, 0};
        b_en = 1; b_ready = 1; b_req = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({b_valid, b_code, b_multi} !== {1'b1, 3'(exp_codes[i]), 1'b1}) begin
                failures++;
                $display("FAIL rr_wrap_%0d got v=%b c=%0d m=%b want v=1 c=%0d m=1", i, b_valid, b_code, b_multi, exp_codes[i]);
            end
        end
        b_en = 0;
        tick();
    endtask

    task automatic test_enable_off();
        b_en = 0; b_ready = 1; b_req = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (b_valid !== 1'b0) begin
                failures++;
                $display("FAIL en_off_%0d got v=%b want v=0", i, b_valid);
            end
        end
        b_en = 1;
        tick();
        checks++;
        if ({b_valid, b_code} !== 4'b1_001) begin
            failures++;
            $display("FAIL en_off_ptr got v=%b c=%0d want v=1 c=1", b_valid, b_code);
        end
        b_en = 0;
        tick();
    endtask

    task automatic test_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            a_en = ($urandom_range(0, 3) != 0);
            a_ready = ($urandom_range(0, 3) != 0);
            a_req = 4'($urandom);
            b_en = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 3) != 0);
            b_req = 5'($urandom);
            tick();
            checks++;
            if ({a_valid, a_code, a_multi, a_cnt} !== {ma.valid, 2'(ma.code), ma.multi, 16'(ma.cnt)}) begin
                failures++;
                $display("FAIL rand_fix_%0d got v=%b c=%0d m=%b n=%0d want v=%b c=%0d m=%b n=%0d",
                         i, a_valid, a_code, a_multi, a_cnt, ma.valid, ma.code, ma.multi, ma.cnt);
            end
            checks++;
            if ({b_valid, b_code, b_multi, b_cnt} !== {mb.valid, 3'(mb.code), mb.multi, 16'(mb.cnt)}) begin
                failures++;
                $display("FAIL rand_rr_%0d got v=%b c=%0d m=%b n=%0d want v=%b c=%0d m=%b n=%0d",
                         i, b_valid, b_code, b_multi, b_cnt, mb.valid, mb.code, mb.multi, mb.cnt);
            end
        end
        a_en = 0; b_en = 0; a_ready = 1; b_ready = 1;
        tick();
    endtask

    task automatic test_async_reset();
        b_en = 1; b_ready = 0; b_req = 5'b01100;
        a_en = 1; a_ready = 0; a_req = 4'b1100;
        tick();
        b_en = 0; a_en = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({b_valid, b_code, b_multi, b_cnt} !== 21'h0) begin
            failures++;
            $display("FAIL async_rst_rr got v=%b c=%0d m=%b n=%0d want all zero", b_valid, b_code, b_multi, b_cnt);
        end
        checks++;
        if ({a_valid, a_code, a_multi, a_cnt} !== 20'h0) begin
            failures++;
            $display("FAIL async_rst_fix got v=%b c=%0d m=%b n=%0d want all zero", a_valid, a_code, a_multi, a_cnt);
        end
        ma = mdl_clear(); mb = mdl_clear();
        b_en = 1; b_ready = 1; b_req = 5'b11111;
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if ({b_valid, b_code} !== 4'b1_000) begin
            failures++;
            $display("FAIL rst_restart got v=%b c=%0d want v=1 c=0", b_valid, b_code);
        end
        tick();
        checks++;
        if ({b_valid, b_code, b_cnt} !== {1'b1, 3'd1, 16'd1}) begin
            failures++;
            $display("FAIL rst_restart2 got v=%b c=%0d n=%0d want v=1 c=1 n=1", b_valid, b_code, b_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_onehot();
        test_fixed_multi();
        test_backpressure();
        test_rr_wrap();
        test_enable_off();
        test_random(400);
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
